// File: rtl/deadlock_report_ctrl.sv
// deadlock_report_ctrl
// Confirms a deadlock after the monitor block flag has been high for
// HOLD_CYCLES consecutive edges. It then snapshots the per-channel block info
// and reports each non-zero channel nibble over a valid/ready handshake.
// Finally it parks in HALT with a sticky flag and a one-cycle stop request.

module deadlock_report_ctrl #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned CW          = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          block_in,
    input  logic [15:0]   axis_block_info_in,
    input  logic          clear,
    output logic          rpt_valid,
    input  logic          rpt_ready,
    output logic [1:0]    rpt_chan,
    output logic [3:0]    rpt_code,
    output logic          deadlock_found,
    output logic          stop_req,
    output logic [CW-1:0] stall_count
);

    typedef enum logic [1:0] {
        StIdle,
        StWatch,
        StReport,
        StHalt
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] stall_q, stall_d;
    logic [CW:0]   stall_inc;
    logic          confirm;
    logic [15:0]   snap_q, snap_d;
    logic          valid_q, valid_d;
    logic [1:0]    chan_q, chan_d;
    logic [3:0]    code_q, code_d;
    logic          found_q, found_d;
    logic          stop_q, stop_d;
    logic [2:0]    first_hit;
    logic [2:0]    next_hit;

    // Lowest channel index >= first whose nibble is non-zero.
    // Result is {found, channel}; found=0 means nothing left.
    function automatic logic [2:0] find_chan(input logic [15:0] info, input logic [2:0] first);
        logic [2:0] res;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            if ((k >= int'(first)) && (info[4*k +: 4] != 4'h0)) begin
                res = {1'b1, k[1:0]};
            end
        end
        return res;
    endfunction

    // One bit wider than the counter so the saturation carry is visible.
    assign stall_inc = {1'b0, stall_q} + {{CW{1'b0}}, 1'b1};

    // The edge that completes a run of HOLD_CYCLES consecutive block cycles.
    assign confirm = block_in && (stall_inc == (CW+1)'(HOLD_CYCLES));

    // First entry comes from the live info word (it is being snapshotted on this
    // edge); later entries walk the stored snapshot past the current channel.
    assign first_hit = find_chan(axis_block_info_in, 3'd0);
    assign next_hit  = find_chan(snap_q, {1'b0, chan_q} + 3'd1);

    // Saturating run-length counter; keeps running in every state.
    always_comb begin
        stall_d = stall_q;
        if (clear || !block_in) begin
            stall_d = '0;
        end else if (!stall_inc[CW]) begin
            stall_d = stall_inc[CW-1:0];
        end
    end

    // Next-state and registered-output logic for the report FSM.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        valid_d = 1'b0;
        chan_d  = 2'd0;
        code_d  = 4'd0;

        if (clear) begin
            state_d = StIdle;
            snap_d  = 16'h0000;
        end else begin
            unique case (state_q)
                StIdle, StWatch: begin
                    if (confirm) begin
                        snap_d = axis_block_info_in;
                        if (first_hit[2]) begin
                            state_d = StReport;
                            valid_d = 1'b1;
                            chan_d  = first_hit[1:0];
                            code_d  = axis_block_info_in[{first_hit[1:0], 2'b00} +: 4];
                        end else begin
                            // Nothing to report; a zero snapshot still halts.
                            state_d = StHalt;
                        end
                    end else if (block_in) begin
                        state_d = StWatch;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StReport: begin
                    if (valid_q && !rpt_ready) begin
                        valid_d = 1'b1;
                        chan_d  = chan_q;
                        code_d  = code_q;
                    end else if (valid_q && next_hit[2]) begin
                        valid_d = 1'b1;
                        chan_d  = next_hit[1:0];
                        code_d  = snap_q[{next_hit[1:0], 2'b00} +: 4];
                    end else begin
                        state_d = StHalt;
                    end
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Flag and pulse derived from the state being entered.
    always_comb begin
        found_d = (state_d == StHalt);
        stop_d  = (state_d == StHalt) && (state_q != StHalt);
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Run counter and info snapshot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            snap_q  <= 16'h0000;
        end else begin
            stall_q <= stall_d;
            snap_q  <= snap_d;
        end
    end

    // Registered report and status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            chan_q  <= 2'd0;
            code_q  <= 4'd0;
            found_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            chan_q  <= chan_d;
            code_q  <= code_d;
            found_q <= found_d;
            stop_q  <= stop_d;
        end
    end

    assign rpt_valid      = valid_q;
    assign rpt_chan       = chan_q;
    assign rpt_code       = code_q;
    assign deadlock_found = found_q;
    assign stop_req       = stop_q;
    assign stall_count    = stall_q;

endmodule

// File: tb/tb_deadlock_report_ctrl.sv
// Bench for deadlock_report_ctrl: two instances (HOLD=16/CW=16 and HOLD=8/CW=4)
// share one stimulus stream and are compared each cycle against a reference
// model built on a run length, a pending-channel mask and a halted flag.

module tb_deadlock_report_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        block_in;
    logic [15:0] info;
    logic        clear;
    logic        rpt_ready;

    logic        valid_a, found_a, stop_a;
    logic [1:0]  chan_a;
    logic [3:0]  code_a;
    logic [15:0] stall_a;

    logic        valid_b, found_b, stop_b;
    logic [1:0]  chan_b;
    logic [3:0]  code_b;
    logic [3:0]  stall_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, index 0 = instance a, 1 = instance b.
    int unsigned hold_m[2];
    int unsigned max_m[2];
    int unsigned run_m[2];
    logic [15:0] snap_m[2];
    logic [3:0]  pend_m[2];
    bit          rep_m[2];
    bit          halt_m[2];
    bit          stp_m[2];

    always #5 clock = ~clock;

    deadlock_report_ctrl #(.HOLD_CYCLES(16), .CW(16)) dut_a (
        .clock              (clock),
        .reset              (reset),
        .block_in           (block_in),
        .axis_block_info_in (info),
        .clear              (clear),
        .rpt_valid          (valid_a),
        .rpt_ready          (rpt_ready),
        .rpt_chan           (chan_a),
        .rpt_code           (code_a),
        .deadlock_found     (found_a),
        .stop_req           (stop_a),
        .stall_count        (stall_a)
    );

    deadlock_report_ctrl #(.HOLD_CYCLES(8), .CW(4)) dut_b (
        .clock              (clock),
        .reset              (reset),
        .block_in           (block_in),
        .axis_block_info_in (info),
        .clear              (clear),
        .rpt_valid          (valid_b),
        .rpt_ready          (rpt_ready),
        .rpt_chan           (chan_b),
        .rpt_code           (code_b),
        .deadlock_found     (found_b),
        .stop_req           (stop_b),
        .stall_count        (stall_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] p);
        for (int k = 0; k < 4; k++) begin
            if (p[k]) return k;
        end
        return 0;
    endfunction

    function automatic logic [3:0] nz_mask(input logic [15:0] v);
        logic [3:0] m;
        for (int k = 0; k < 4; k++) m[k] = (v[4*k +: 4] != 4'h0);
        return m;
    endfunction

    function automatic logic [15:0] rand_info();
        logic [15:0] v;
        v = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 1) == 1) v[4*k +: 4] = 4'($urandom_range(1, 15));
        end
        if (v == 16'h0000) v[3:0] = 4'($urandom_range(1, 15));
        return v;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            run_m[m]  = 0;
            snap_m[m] = 16'h0000;
            pend_m[m] = 4'h0;
            rep_m[m]  = 1'b0;
            halt_m[m] = 1'b0;
            stp_m[m]  = 1'b0;
        end
    endtask

    // One clock edge of the model using the inputs held across that edge.
    task automatic model_step(input int m);
        bit showing;
        showing  = rep_m[m] && (pend_m[m] != 4'h0);
        stp_m[m] = 1'b0;
        if (clear) begin
            run_m[m]  = 0;
            snap_m[m] = 16'h0000;
            pend_m[m] = 4'h0;
            rep_m[m]  = 1'b0;
            halt_m[m] = 1'b0;
        end else begin
            if (!halt_m[m]) begin
                if (rep_m[m]) begin
                    if (showing && rpt_ready) pend_m[m][lowest(pend_m[m])] = 1'b0;
                    if (pend_m[m] == 4'h0) begin
                        rep_m[m]  = 1'b0;
                        halt_m[m] = 1'b1;
                        stp_m[m]  = 1'b1;
                    end
                end else if (block_in && (run_m[m] + 1 == hold_m[m])) begin
                    snap_m[m] = info;
                    pend_m[m] = nz_mask(info);
                    if (pend_m[m] == 4'h0) begin
                        halt_m[m] = 1'b1;
                        stp_m[m]  = 1'b1;
                    end else begin
                        rep_m[m] = 1'b1;
                    end
                end
            end
            if (!block_in) run_m[m] = 0;
            else if (run_m[m] < max_m[m]) run_m[m] = run_m[m] + 1;
        end
    endtask

    task automatic check_dut(input int m, input logic v, input logic [1:0] ch, input logic [3:0] cd,
                             input logic f, input logic s, input logic [15:0] st);
        bit   exp_v;
        int   c;
        string p;
        p     = (m == 0) ? "a" : "b";
        exp_v = rep_m[m] && (pend_m[m] != 4'h0);
        check_eq($sformatf("%s.rpt_valid", p), {31'b0, v}, {31'b0, exp_v});
        if (exp_v) begin
            c = lowest(pend_m[m]);
            check_eq($sformatf("%s.rpt_chan", p), {30'b0, ch}, c);
            check_eq($sformatf("%s.rpt_code", p), {28'b0, cd}, {28'b0, snap_m[m][4*c +: 4]});
        end
        check_eq($sformatf("%s.deadlock_found", p), {31'b0, f}, {31'b0, halt_m[m]});
        check_eq($sformatf("%s.stop_req", p), {31'b0, s}, {31'b0, stp_m[m]});
        check_eq($sformatf("%s.stall_count", p), {16'b0, st}, run_m[m]);
    endtask

    task automatic check_both();
        check_dut(0, valid_a, chan_a, code_a, found_a, stop_a, stall_a);
        check_dut(1, valid_b, chan_b, code_b, found_b, stop_b, {12'b0, stall_b});
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        model_step(0);
        model_step(1);
        check_both();
    endtask

    task automatic clear_cycle();
        block_in = 1'b0;
        clear    = 1'b1;
        cycle();
        clear    = 1'b0;
    endtask

    initial begin
        hold_m[0] = 16;
        max_m[0]  = 65535;
        hold_m[1] = 8;
        max_m[1]  = 15;
        model_reset();

        reset     = 1'b1;
        block_in  = 1'b0;
        info      = 16'h0000;
        clear     = 1'b0;
        rpt_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_both();
        reset = 1'b0;

        // 1: 16-edge confirm with ready high, then halt with a single stop pulse
        info      = 16'hFFFE;
        block_in  = 1'b1;
        rpt_ready = 1'b1;
        repeat (16) cycle();
        check_eq("t1.valid", {31'b0, valid_a}, 32'd1);
        check_eq("t1.chan", {30'b0, chan_a}, 32'd0);
        check_eq("t1.code", {28'b0, code_a}, 32'hE);
        repeat (6) cycle();
        check_eq("t1.found", {31'b0, found_a}, 32'd1);

        // 2: 15-edge run falls short, counter then drops to zero
        clear_cycle();
        block_in = 1'b1;
        repeat (15) cycle();
        check_eq("t2.stall15", {16'b0, stall_a}, 32'd15);
        check_eq("t2.novalid", {31'b0, valid_a}, 32'd0);
        block_in = 1'b0;
        cycle();
        check_eq("t2.stall0", {16'b0, stall_a}, 32'd0);

        // 3: back-pressure holds chan0, then chan2 and chan3 back to back
        clear_cycle();
        info      = 16'h7B0E;
        rpt_ready = 1'b0;
        block_in  = 1'b1;
        repeat (16) cycle();
        repeat (5) cycle();
        check_eq("t3.held_chan", {30'b0, chan_a}, 32'd0);
        check_eq("t3.held_code", {28'b0, code_a}, 32'hE);
        rpt_ready = 1'b1;
        cycle();
        check_eq("t3.chan2", {30'b0, chan_a}, 32'd2);
        check_eq("t3.codeB", {28'b0, code_a}, 32'hB);
        cycle();
        check_eq("t3.chan3", {30'b0, chan_a}, 32'd3);
        check_eq("t3.code7", {28'b0, code_a}, 32'h7);
        repeat (3) cycle();

        // 4: clear during the second beat with block still high
        clear_cycle();
        block_in = 1'b1;
        repeat (17) cycle();
        clear     = 1'b1;
        rpt_ready = 1'b0;
        cycle();
        clear     = 1'b0;
        rpt_ready = 1'b1;
        check_eq("t4.valid0", {31'b0, valid_a}, 32'd0);
        check_eq("t4.stall0", {16'b0, stall_a}, 32'd0);
        repeat (15) cycle();
        check_eq("t4.not_yet", {31'b0, valid_a}, 32'd0);
        cycle();
        check_eq("t4.again", {31'b0, valid_a}, 32'd1);

        // 5: asynchronous reset between edges while watching
        clear_cycle();
        block_in = 1'b1;
        repeat (5) cycle();
        #2;
        reset = 1'b1;
        #1;
        check_eq("t5.valid", {31'b0, valid_a}, 32'd0);
        check_eq("t5.found", {31'b0, found_a}, 32'd0);
        check_eq("t5.stop", {31'b0, stop_a}, 32'd0);
        check_eq("t5.stall", {16'b0, stall_a}, 32'd0);
        check_eq("t5.stall_b", {28'b0, stall_b}, 32'd0);
        model_reset();
        @(posedge clock);
        #1;
        check_both();
        reset = 1'b0;

        // 6: long run saturates the narrow counter and halts once
        clear_cycle();
        info      = rand_info();
        rpt_ready = 1'b1;
        block_in  = 1'b1;
        repeat (30) cycle();
        check_eq("t6.sat", {28'b0, stall_b}, 32'd15);
        check_eq("t6.found_b", {31'b0, found_b}, 32'd1);
        check_eq("t6.stall_a", {16'b0, stall_a}, 32'd30);

        // Randomized episodes: runs of varying length, random ready and clears
        for (int ep = 0; ep < 80; ep++) begin
            int len;
            info = rand_info();
            len  = $urandom_range(1, 24);
            for (int c = 0; c < len; c++) begin
                block_in  = 1'b1;
                rpt_ready = ($urandom_range(0, 2) != 0);
                clear     = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 9) == 0) info = rand_info();
                cycle();
            end
            clear = 1'b0;
            for (int g = 0; g < int'($urandom_range(1, 6)); g++) begin
                block_in  = ($urandom_range(0, 3) == 0);
                rpt_ready = ($urandom_range(0, 2) != 0);
                cycle();
            end
            if ($urandom_range(0, 1) == 1) clear_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
